// File: rtl/seq_mem_mwport_clr.sv
// rtl/seq_mem_mwport_clr.sv - multi-write-port masked memory with post-reset clear sweep
// Ports merge in ascending index so the highest-index port owns each masked bit.
module seq_mem_mwport_clr #(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 16,
  parameter int NUM_WR         = 2,
  parameter int RD_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*DATA_W-1:0] wr_mask,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     init_busy,
  output logic                     err_oob
);

  typedef enum logic {INIT, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem      [DEPTH];
  logic [DATA_W-1:0]   mem_next [DEPTH];
  logic                wr_oob;
  logic                rd_oob;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  assign rd_oob    = !in_range(rd_addr);
  assign init_busy = (state_q == INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? INIT : READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = READY;
        ptr_d   = '0;
      end
    end
  end

  // Merged post-write image; also feeds the write-first read path.
  always_comb begin
    mem_next = mem;
    wr_oob   = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) begin
        if (in_range(wr_addr[i*ADDR_W +: ADDR_W])) begin
          mem_next[wr_addr[i*ADDR_W +: ADDR_W]] =
              (mem_next[wr_addr[i*ADDR_W +: ADDR_W]] & ~wr_mask[i*DATA_W +: DATA_W]) |
              (wr_data[i*DATA_W +: DATA_W] & wr_mask[i*DATA_W +: DATA_W]);
        end else begin
          wr_oob = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) begin
        mem[ptr_q] <= '0;
      end else begin
        for (int r = 0; r < DEPTH; r++) begin
          mem[r] <= mem_next[r];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err_oob  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state_q == READY) begin
        if (rd_en) begin
          rd_valid <= 1'b1;
          if (rd_oob) begin
            rd_data <= '0;
          end else if (RD_MODE != 0) begin
            rd_data <= mem_next[rd_addr];
          end else begin
            rd_data <= mem[rd_addr];
          end
        end
        if (wr_oob || (rd_en && rd_oob)) begin
          err_oob <= 1'b1;
        end
      end
    end
  end

endmodule
